// File: rtl/reg_mem_arb_pkg.sv
// Shared types and constants for the two-master reg_mem arbiter.
package reg_mem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with an eligibility mask; the pointer moves past each winner.
module rr_arb2
    import reg_mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic [NUM_REQ-1:0] grant_o
);

    req_id_t            ptr_q;
    req_id_t            ptr_d;
    logic [NUM_REQ-1:0] elig;

    always_comb begin
        elig    = req_i & ~mask_i;
        grant_o = elig;
        if (elig == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
        // Granting master 0 makes master 1 preferred, and vice versa.
        ptr_d = ptr_q;
        if (grant_o != '0) begin
            ptr_d = req_id_t'(grant_o[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_mem_arbiter.sv
// Shares one reg_mem between two masters: round-robin grant, optional lock with
// hold timeout, and one-cycle read data return to the issuing master.
module reg_mem_arbiter
    import reg_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 5,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  lock0,
    input  logic [ADDR_BITS-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [ADDR_BITS-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid1,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  lock_timeout
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic                hold_last;
    logic                timeout_q;
    logic                rv_q;
    req_id_t             rid_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [NUM_REQ-1:0]  mask;
    logic [NUM_REQ-1:0]  grant;
    logic                xfer0;
    logic                xfer1;

    // Requests are ignored while in reset so nothing is acked or issued.
    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({req1, req0} & {NUM_REQ{~rst}}),
        .mask_i  (mask),
        .grant_o (grant)
    );

    assign xfer0     = grant[0];
    assign xfer1     = grant[1];
    assign hold_last = (state_q != IDLE) && (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (xfer0 && lock0)      state_d = LOCK0;
                else if (xfer1 && lock1) state_d = LOCK1;
            end
            LOCK0: if (hold_last || (xfer0 && !lock0)) state_d = IDLE;
            LOCK1: if (hold_last || (xfer1 && !lock1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        hold_d = (state_q == IDLE) ? '0 : hold_q + HOLD_W'(1);
    end

    always_comb begin
        mask     = '0;
        mem_addr = '0;
        mem_din  = '0;
        mem_wen  = 1'b0;
        case (state_q)
            LOCK0:   mask = 2'b10;
            LOCK1:   mask = 2'b01;
            default: mask = 2'b00;
        endcase
        if (xfer0) begin
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_wen  = we0;
        end else if (xfer1) begin
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_wen  = we1;
        end
    end

    assign ack0 = xfer0;
    assign ack1 = xfer1;

    // Read return tracking, hold counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
            rv_q      <= 1'b0;
            rid_q     <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= hold_last;
            rv_q      <= (xfer0 || xfer1) && !mem_wen;
            rid_q     <= req_id_t'(xfer1);
            if (rvalid0) rdata0_q <= mem_dout;
            if (rvalid1) rdata1_q <= mem_dout;
        end
    end

    // A response pending across a reset is dropped, and outputs read as reset values.
    assign rvalid0      = rv_q && !rst && (rid_q == 1'b0);
    assign rvalid1      = rv_q && !rst && (rid_q == 1'b1);
    assign rdata0       = rst ? '0 : (rvalid0 ? mem_dout : rdata0_q);
    assign rdata1       = rst ? '0 : (rvalid1 ? mem_dout : rdata1_q);
    assign lock_timeout = timeout_q && !rst;

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// Randomized and directed bench for reg_mem_arbiter against a transaction-level model.
module tb_reg_mem_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [4:0] addr0, addr1, mem_addr;
    logic [7:0] wdata0, wdata1, mem_din, mem_dout;
    logic       ack0, ack1, rvalid0, rvalid1, mem_wen, lock_timeout;
    logic [7:0] rdata0, rdata1;

    // Stimulus per master
    logic       r_req[2], r_we[2], r_lock[2];
    logic [4:0] r_addr[2];
    logic [7:0] r_data[2];

    assign req0 = r_req[0]; assign we0 = r_we[0]; assign lock0 = r_lock[0];
    assign addr0 = r_addr[0]; assign wdata0 = r_data[0];
    assign req1 = r_req[1]; assign we1 = r_we[1]; assign lock1 = r_lock[1];
    assign addr1 = r_addr[1]; assign wdata1 = r_data[1];

    reg_mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .mem_dout(mem_dout), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // External reg_mem: synchronous write, registered read
    logic [7:0] ram[32];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state: who owns a lock, how long held, preference, pending read
    int         owner, hold, pref, pid, last_g;
    bit         pv, to_p;
    logic [7:0] pdata;
    logic [7:0] last[2];
    logic [7:0] mm[32];

    task automatic step();
        int  g;
        bit  e0, e1;
        #1;
        g  = -1;
        e0 = !rst && r_req[0] && (owner < 0 || owner == 0);
        e1 = !rst && r_req[1] && (owner < 0 || owner == 1);
        if (e0 && e1)  g = pref;
        else if (e0)   g = 0;
        else if (e1)   g = 1;

        check_eq("ack0", 32'(ack0), 32'(g == 0));
        check_eq("ack1", 32'(ack1), 32'(g == 1));
        check_eq("mem_wen", 32'(mem_wen), (g >= 0) ? 32'(r_we[g]) : 32'd0);
        check_eq("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(r_addr[g]) : 32'd0);
        check_eq("mem_din", 32'(mem_din), (g >= 0) ? 32'(r_data[g]) : 32'd0);
        check_eq("rvalid0", 32'(rvalid0), 32'(!rst && pv && pid == 0));
        check_eq("rvalid1", 32'(rvalid1), 32'(!rst && pv && pid == 1));
        check_eq("rdata0", 32'(rdata0), rst ? 32'd0 : ((pv && pid == 0) ? 32'(pdata) : 32'(last[0])));
        check_eq("rdata1", 32'(rdata1), rst ? 32'd0 : ((pv && pid == 1) ? 32'(pdata) : 32'(last[1])));
        check_eq("lock_timeout", 32'(lock_timeout), 32'(!rst && to_p));

        if (rst) begin
            owner = -1; hold = 0; pref = 0; pv = 0; to_p = 0;
            last[0] = '0; last[1] = '0;
        end else begin
            if (pv) last[pid] = pdata;
            to_p = (owner >= 0) && (hold == MAXH - 1);
            pv   = (g >= 0) && !r_we[g];
            if (pv) begin pid = g; pdata = mm[r_addr[g]]; end
            if (g >= 0 && r_we[g]) mm[r_addr[g]] = r_data[g];
            if (g >= 0) pref = 1 - g;
            if (owner >= 0) begin
                if (hold == MAXH - 1 || (g == owner && !r_lock[g])) begin
                    pref  = 1 - owner;
                    owner = -1;
                end else begin
                    hold++;
                end
            end else if (g >= 0 && r_lock[g]) begin
                owner = g;
                hold  = 0;
            end
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_m(input int id, input logic rq, input logic w, input logic lk,
                         input logic [4:0] a, input logic [7:0] d);
        r_req[id] = rq; r_we[id] = w; r_lock[id] = lk; r_addr[id] = a; r_data[id] = d;
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, 0, 5'd0, 8'd0);
        set_m(1, 0, 0, 0, 5'd0, 8'd0);
    endtask

    initial begin
        bit pend[2];
        for (int i = 0; i < 32; i++) begin
            ram[i] = 8'($urandom);
            mm[i]  = ram[i];
        end
        owner = -1; hold = 0; pref = 0; pv = 0; to_p = 0; pid = 0; pdata = '0;
        last[0] = '0; last[1] = '0; last_g = -1;
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        step();

        // Write then read back on master 0
        set_m(0, 1, 1, 0, 5'd10, 8'h80); step();
        set_m(0, 1, 0, 0, 5'd10, 8'h00); step();
        idle_all(); #1;
        check_eq("rd_back_valid", 32'(rvalid0), 32'd1);
        check_eq("rd_back_data", 32'(rdata0), 32'h80);
        step(); step();

        // Both read continuously: alternating grants
        set_m(0, 1, 0, 0, 5'd3, 8'd0);
        set_m(1, 1, 0, 0, 5'd4, 8'd0);
        repeat (6) step();
        idle_all(); step(); step();

        // Master 1 alone, then contention
        set_m(1, 1, 0, 0, 5'd7, 8'd0);
        repeat (4) step();
        set_m(0, 1, 0, 0, 5'd8, 8'd0); #1;
        check_eq("m0_after_m1_run", 32'(ack0), 32'd1);
        repeat (3) step();
        idle_all(); step(); step();

        // Locked read-modify-write
        set_m(0, 1, 0, 1, 5'd5, 8'd0);
        set_m(1, 1, 1, 0, 5'd6, 8'h3c);
        step();
        step();
        set_m(0, 1, 1, 0, 5'd5, 8'h5a); step();
        set_m(0, 0, 0, 0, 5'd0, 8'd0); step();
        idle_all(); step(); step();

        // Lock then idle: forced release after MAX_HOLD cycles
        set_m(0, 1, 0, 1, 5'd9, 8'd0);
        set_m(1, 1, 0, 0, 5'd11, 8'd0);
        step();
        set_m(0, 0, 0, 0, 5'd0, 8'd0);
        repeat (MAXH) step();
        #1;
        check_eq("timeout_pulse", 32'(lock_timeout), 32'd1);
        check_eq("m1_after_timeout", 32'(ack1), 32'd1);
        step();
        idle_all(); step(); step();

        // Reset while a read response is in flight
        set_m(1, 1, 0, 0, 5'd12, 8'd0); step();
        idle_all(); rst = 1'b1; step();
        rst = 1'b0; step();
        set_m(0, 1, 0, 0, 5'd13, 8'd0);
        set_m(1, 1, 0, 0, 5'd14, 8'd0);
        repeat (4) step();
        idle_all(); step();

        // Random traffic; requests hold until the model grants them
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    set_m(m, ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 31)), 8'($urandom));
                    pend[m] = r_req[m];
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            if (last_g >= 0) pend[last_g] = 0;
        end
        rst = 1'b0;
        idle_all();
        repeat (MAXH + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
